player_painter: RTL and testbench
=================================

# player_painter

Game-stage framebuffer painter on the `clk_33m` screen domain. It consumes the `jumping`/`ducking` motion flags and advances a player sprite's jump physics once per frame. Each frame it erases the old sprite and draws the new one into the VGA framebuffer through the `write_x`/`write_y`/`write_palette` pixel-write port, one pixel per cycle. It replaces the paint demo as the framebuffer writer.

## Interface
Parameters:
- `PLAYER_X`, 100: left column of sprite.
- `PLAYER_W`, 32: sprite width, in pixels.
- `PLAYER_H`, 64: standing height.
- `DUCK_H`, 32: ducking height.
- `GROUND_Y`, 400: first row below the sprite when it is grounded.
- `JUMP_V0`, 20: launch velocity, in pixels/frame.
- `GRAVITY`, 1: velocity decrement per frame.

Ports:
- `clk_33m`, in, 1: screen-domain clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse per displayed frame.
- `jumping`, in, 1: jump request; asynchronous to `clk_33m`.
- `ducking`, in, 1: duck request; asynchronous to `clk_33m`.
- `write_en`, out, 1: pixel write strobe; qualifies x/y/palette in the same cycle.
- `write_x`, out, 11: pixel column.
- `write_y`, out, 11: pixel row.
- `write_palette`, out, 2: 0 = background, 1 = body, 2 = outline.
- `busy`, out, 1: erase/update/draw sequence in progress.
- `height`, out, 11: current altitude above ground, for debug.
- `overrun`, out, 1: sticky; a `frame_tick` was dropped.

## Operation
Input synchronisation:
- `jumping` and `ducking` each pass through a 2-flop synchroniser: `jump_s` and `duck_s`.

State machine:
- States: IDLE, ERASE, UPDATE, DRAW.
- IDLE → ERASE on `frame_tick`.
- ERASE → UPDATE after the last pixel of the old box.
- UPDATE lasts exactly 1 cycle, then → DRAW.
- DRAW → IDLE after the last pixel of the new box.

Box geometry:
- Box spans x = `PLAYER_X` .. `PLAYER_X+PLAYER_W-1`.
- Box spans y = `GROUND_Y-height-box_h` .. `GROUND_Y-height-1`.
- `box_h` is `DUCK_H` when the ducking flag is set, otherwise `PLAYER_H`.
- Scan order is row-major: x increments first, then y.

ERASE:
- Repaints the previous frame's box with palette 0.
- The old top and old `box_h` are latched.

UPDATE: `v` is a signed 8-bit velocity, `height` is unsigned 11-bit. Exactly one rule applies:
- `height==0` and `jump_s`: `height←JUMP_V0`, `v←JUMP_V0-GRAVITY`.
- `height!=0` and `height+v<=0`: landing, so `height←0`, `v←0`.
- `height!=0` otherwise: `height←height+v`, `v←v-GRAVITY`.
- `height==0` without `jump_s`: `height` and `v` are unchanged.

Ducking flag:
- Updated in UPDATE as `duck_s && !jump_s` while grounded; the flag equals `duck_s && !jump_s`.
- When airborne after the update, the flag is forced to 0. `ducking` is ignored in the air.
- Jump wins over a simultaneous duck.

DRAW:
- Paints the new box with palette 1.

Arithmetic:
- Geometry is computed in 12-bit and truncated to 11-bit.
- Parameters must satisfy `GROUND_Y > PLAYER_H + peak height`. No clipping is performed.

## Timing
Reset values (applied immediately on `rst`, including mid-sequence):
- All of `write_en`, `write_x`, `write_y`, `write_palette`, `busy`, `height`, `v`, `overrun` are 0.
- Ducking flag is 0; state is IDLE.
- The latched old box is the standing box on the ground.

Frame sequence, with `frame_tick` sampled in IDLE at cycle 0:
- ERASE writes occupy cycles 1 .. `W·H_old`.
- UPDATE occupies 1 cycle; `write_en` is 0 in that cycle.
- DRAW writes occupy the next `W·H_new` cycles.
- `busy` is 1 from cycle 1 through the last DRAW cycle; it is 0 in IDLE.

Outputs:
- `write_*` are registered.
- `write_x`/`write_y`/`write_palette` hold their last values when `write_en` is 0.

Dropped ticks:
- A `frame_tick` arriving while `busy` is 1 (including the final DRAW cycle) is dropped and sets `overrun`.
- `overrun` clears only on `rst`.

Synchroniser latency:
- A request is seen by UPDATE only if it was asserted ≥2 cycles before the UPDATE cycle.

## Configuration
`PLAYER_PAINTER_OUTLINE_EN`:
- Defined: during DRAW, pixels on the box border (first/last row, first/last column) use palette 2, and the interior uses palette 1.
- Undefined: the whole box uses palette 1 and palette 2 is never emitted.
- ERASE and timing are identical in both cases.

## Test plan
- **Reset and idle frame.** Reset, then one `frame_tick` with no inputs → 2048 writes of palette 0 at x 100..131, y 336..399. Then 1 idle cycle. Then 2048 writes of palette 1 over the same box. `busy` falls at cycle 4098.
- **Full jump arc.** Hold `jumping` for one frame, then release, then tick every frame → `height` = 20, 39, 57, …, peak 210 at frames 20–21. `height` = 20 at frame 40, lands at 0 on frame 41 with `v`=0.
- **Duck and landing.** Assert `ducking` on the ground → next DRAW box is y 368..399 (1024 writes), and the following ERASE covers 1024 pixels. Assert `ducking` while airborne → `box_h` stays 64.
- **Simultaneous jump and duck.** Both asserted on the ground → jump taken: `height`=20, box 64 rows at y 316..379.
- **Frame overrun.** Pulse `frame_tick` at cycle 2000 of a sequence → no restart and `overrun`=1; `overrun` holds until `rst`.
- **Reset mid-DRAW.** Assert `rst` mid-DRAW → `write_en` low immediately and all outputs at reset values. The next frame erases the standing box.

Source files
------------

// File: rtl/player_painter.sv
// Player sprite painter: per-frame erase / physics update / redraw into the framebuffer write port.
// Optional `PLAYER_PAINTER_OUTLINE_EN draws the sprite border with palette 2.
module player_painter #(
  parameter int PLAYER_X = 100,
  parameter int PLAYER_W = 32,
  parameter int PLAYER_H = 64,
  parameter int DUCK_H   = 32,
  parameter int GROUND_Y = 400,
  parameter int JUMP_V0  = 20,
  parameter int GRAVITY  = 1
) (
  input  logic        clk_33m,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        jumping,
  input  logic        ducking,
  output logic        write_en,
  output logic [10:0] write_x,
  output logic [10:0] write_y,
  output logic [1:0]  write_palette,
  output logic        busy,
  output logic [10:0] height,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;

  state_t             state_q, state_d;
  logic [1:0]         jump_sync_q, duck_sync_q;
  logic               jump_s, duck_s;
  logic [10:0]        cx_q, cx_d, cy_q, cy_d;
  logic [10:0]        top_q, top_d, boxh_q, boxh_d;
  logic [10:0]        height_q, height_d;
  logic signed [7:0]  v_q, v_d;
  logic               duck_q, duck_d, overrun_q, overrun_d;
  logic               wen_q, wen_d;
  logic [10:0]        wx_q, wx_d, wy_q, wy_d;
  logic [1:0]         wpal_q, wpal_d;

  logic [10:0]        cur_h, cur_top, new_h, new_top, nx, ny;
  logic               last_col, last_px;
  logic signed [12:0] sum;
  logic [1:0]         pal_first, pal_adv;

  assign jump_s = jump_sync_q[1];
  assign duck_s = duck_sync_q[1];

  always_comb begin
    cur_h    = duck_q ? 11'(DUCK_H) : 11'(PLAYER_H);
    cur_top  = 11'(12'(GROUND_Y) - {1'b0, height_q} - {1'b0, cur_h});
    last_col = (cx_q == 11'(PLAYER_W - 1));
    last_px  = last_col && (cy_q == boxh_q - 11'd1);
    nx       = last_col ? 11'd0 : cx_q + 11'd1;
    ny       = last_col ? cy_q + 11'd1 : cy_q;
    sum      = $signed({2'b00, height_q}) + $signed({{5{v_q[7]}}, v_q});
`ifdef PLAYER_PAINTER_OUTLINE_EN
    pal_first = 2'd2;
    pal_adv   = (nx == 11'd0 || nx == 11'(PLAYER_W - 1) || ny == 11'd0 || ny == boxh_q - 11'd1)
                ? 2'd2 : 2'd1;
`else
    pal_first = 2'd1;
    pal_adv   = 2'd1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    top_d     = top_q;
    boxh_d    = boxh_q;
    height_d  = height_q;
    v_d       = v_q;
    duck_d    = duck_q;
    wen_d     = 1'b0;
    wx_d      = wx_q;
    wy_d      = wy_q;
    wpal_d    = wpal_q;
    new_h     = 11'(PLAYER_H);
    new_top   = 11'd0;
    overrun_d = overrun_q | (frame_tick & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = ERASE;
          top_d   = cur_top;
          boxh_d  = cur_h;
          cx_d    = 11'd0;
          cy_d    = 11'd0;
          wen_d   = 1'b1;
          wx_d    = 11'(PLAYER_X);
          wy_d    = cur_top;
          wpal_d  = 2'd0;
        end
      end
      ERASE, DRAW: begin
        if (last_px) begin
          state_d = (state_q == ERASE) ? UPDATE : IDLE;
        end else begin
          cx_d   = nx;
          cy_d   = ny;
          wen_d  = 1'b1;
          wx_d   = 11'(PLAYER_X) + nx;
          wy_d   = top_q + ny;
          wpal_d = (state_q == ERASE) ? 2'd0 : pal_adv;
        end
      end
      UPDATE: begin
        if (height_q == 11'd0) begin
          if (jump_s) begin
            height_d = 11'(JUMP_V0);
            v_d      = 8'(JUMP_V0 - GRAVITY);
          end
        end else if (sum <= 13'sd0) begin
          height_d = 11'd0;
          v_d      = 8'sd0;
        end else begin
          height_d = sum[10:0];
          v_d      = v_q - 8'(GRAVITY);
        end
        // Ducking only sticks while grounded; a jump request overrides it.
        duck_d  = (height_d == 11'd0) && duck_s && !jump_s;
        new_h   = duck_d ? 11'(DUCK_H) : 11'(PLAYER_H);
        new_top = 11'(12'(GROUND_Y) - {1'b0, height_d} - {1'b0, new_h});
        state_d = DRAW;
        top_d   = new_top;
        boxh_d  = new_h;
        cx_d    = 11'd0;
        cy_d    = 11'd0;
        wen_d   = 1'b1;
        wx_d    = 11'(PLAYER_X);
        wy_d    = new_top;
        wpal_d  = pal_first;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      jump_sync_q <= 2'b00;
      duck_sync_q <= 2'b00;
      cx_q        <= 11'd0;
      cy_q        <= 11'd0;
      top_q       <= 11'(GROUND_Y - PLAYER_H);
      boxh_q      <= 11'(PLAYER_H);
      height_q    <= 11'd0;
      v_q         <= 8'sd0;
      duck_q      <= 1'b0;
      overrun_q   <= 1'b0;
      wen_q       <= 1'b0;
      wx_q        <= 11'd0;
      wy_q        <= 11'd0;
      wpal_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      jump_sync_q <= {jump_sync_q[0], jumping};
      duck_sync_q <= {duck_sync_q[0], ducking};
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      top_q       <= top_d;
      boxh_q      <= boxh_d;
      height_q    <= height_d;
      v_q         <= v_d;
      duck_q      <= duck_d;
      overrun_q   <= overrun_d;
      wen_q       <= wen_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      wpal_q      <= wpal_d;
    end
  end

  assign write_en      = wen_q;
  assign write_x       = wx_q;
  assign write_y       = wy_q;
  assign write_palette = wpal_q;
  assign busy          = (state_q != IDLE);
  assign height        = height_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_player_painter.sv
// Bench for player_painter: per-frame pixel stream checked against a jump-physics reference model.
module tb_player_painter;
  localparam int PX = 100, W = 8, PH = 64, DH = 32, GY = 400, JV0 = 20, GRAV = 1;

  logic        clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, jumping = 1'b0, ducking = 1'b0;
  logic        write_en, busy, overrun;
  logic [10:0] write_x, write_y, height;
  logic [1:0]  write_palette;

  always #5 clk = ~clk;

  player_painter #(.PLAYER_X(PX), .PLAYER_W(W), .PLAYER_H(PH), .DUCK_H(DH),
                   .GROUND_Y(GY), .JUMP_V0(JV0), .GRAVITY(GRAV)) dut (
    .clk_33m(clk), .rst(rst), .frame_tick(frame_tick), .jumping(jumping), .ducking(ducking),
    .write_en(write_en), .write_x(write_x), .write_y(write_y), .write_palette(write_palette),
    .busy(busy), .height(height), .overrun(overrun));

  int n_cmp = 0, n_bad = 0;
  int m_h = 0, m_v = 0;
  bit m_duck = 0, m_ovr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int box_h(input bit d);
    return d ? DH : PH;
  endfunction

  function automatic logic [1:0] exp_pal(input int col, input int row, input int bh);
    logic [1:0] p;
    p = 2'd1;
`ifdef PLAYER_PAINTER_OUTLINE_EN
    if (col == 0 || col == W - 1 || row == 0 || row == bh - 1) p = 2'd2;
`endif
    return p;
  endfunction

  // Reference physics: one step per frame, taken in the order the rules read.
  task automatic model_update(input bit j, input bit d);
    if (m_h == 0) begin
      if (j) begin m_h = JV0; m_v = JV0 - GRAV; end
    end else if (m_h + m_v <= 0) begin
      m_h = 0; m_v = 0;
    end else begin
      m_h = m_h + m_v; m_v = m_v - GRAV;
    end
    m_duck = (m_h == 0) && d && !j;
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_duck = 0; m_ovr = 0;
  endtask

  // tick_at: 0 = no extra tick, >0 = extra tick in that cycle, <0 = extra tick in the last DRAW cycle.
  task automatic run_frame(input bit j, input bit d, input int tick_at, input string tag);
    int old_top, old_bh, new_top, new_bh, n_old, n_new, total, idx, bad, first_bad, writes;
    logic [10:0] ex, ey;
    logic [1:0]  ep;
    logic        een, ebusy;
    @(negedge clk);
    jumping = j; ducking = d;
    repeat (3) @(negedge clk);
    old_bh  = box_h(m_duck);
    old_top = GY - m_h - old_bh;
    model_update(j, d);
    new_bh  = box_h(m_duck);
    new_top = GY - m_h - new_bh;
    n_old = W * old_bh; n_new = W * new_bh; total = n_old + 1 + n_new;
    if (tick_at != 0) m_ovr = 1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    bad = 0; first_bad = 0; writes = 0;
    ex = 11'd0; ey = 11'd0; ep = 2'd0;
    for (int cyc = 1; cyc <= total + 2; cyc++) begin
      een = 1'b0;
      if (cyc <= n_old) begin
        idx = cyc - 1; een = 1'b1;
        ex = 11'(PX + idx % W); ey = 11'(old_top + idx / W); ep = 2'd0;
      end else if (cyc > n_old + 1 && cyc <= total) begin
        idx = cyc - n_old - 2; een = 1'b1;
        ex = 11'(PX + idx % W); ey = 11'(new_top + idx / W); ep = exp_pal(idx % W, idx / W, new_bh);
      end
      ebusy = (cyc <= total);
      if (write_en === 1'b1) writes++;
      if (write_en !== een || busy !== ebusy || write_x !== ex || write_y !== ey ||
          write_palette !== ep) begin
        bad++;
        if (first_bad == 0) first_bad = cyc;
      end
      frame_tick = (cyc == tick_at) || (tick_at < 0 && cyc == total);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    if (bad != 0) $display("  %s: first bad pixel/cycle at cycle %0d of %0d", tag, first_bad, total);
    check({tag, " bad cycles"}, bad, 0);
    check({tag, " write count"}, writes, n_old + n_new);
    check({tag, " height"}, height, m_h);
    check({tag, " overrun"}, overrun, m_ovr);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst write_en", write_en, 0);
    check("rst busy", busy, 0);
    check("rst height", height, 0);
    check("rst overrun", overrun, 0);
    check("rst write_x", write_x, 0);
    check("rst write_y", write_y, 0);
    check("rst palette", write_palette, 0);
    rst = 1'b0;
    model_reset();

    // Idle frame: standing box at y 336..399 erased then redrawn
    run_frame(0, 0, 0, "idle");

    // Full jump arc with random ducking while airborne
    run_frame(1, 0, 0, "jump f1");
    check("arc f1 height", height, 20);
    for (int f = 2; f <= 41; f++) begin
      run_frame(0, (f <= 40) ? 1'($urandom % 2) : 1'b0, 0, $sformatf("arc f%0d", f));
      if (f == 20 || f == 21) check("arc peak", height, 210);
      if (f == 40) check("arc f40 height", height, 20);
      if (f == 41) check("arc landed", height, 0);
    end
    run_frame(0, 0, 0, "after land");
    check("stays grounded", height, 0);

    // Ducking on the ground, then stand back up
    run_frame(0, 1, 0, "duck1");
    run_frame(0, 1, 0, "duck2");
    run_frame(0, 0, 0, "unduck");

    // Jump beats a simultaneous duck
    run_frame(1, 1, 0, "jump+duck");
    check("jump+duck height", height, 20);

    // Reset mid-DRAW while airborne
    @(negedge clk);
    jumping = 1'b0; ducking = 1'b0;
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (W * PH + 1 + 10) @(negedge clk);
    check("pre-rst in draw", busy, 1);
    rst = 1'b1;
    #1;
    check("mid rst write_en", write_en, 0);
    check("mid rst busy", busy, 0);
    check("mid rst height", height, 0);
    check("mid rst write_x", write_x, 0);
    check("mid rst write_y", write_y, 0);
    check("mid rst palette", write_palette, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 0, 0, "post rst");

    // Dropped ticks: mid-sequence, sticky, cleared by reset, and on the final DRAW cycle
    run_frame(0, 0, 200, "ovr mid");
    run_frame(0, 0, 0, "ovr sticky");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ovr cleared", overrun, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 0, -1, "ovr last");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random requests
    for (int k = 0; k < 12; k++)
      run_frame(1'($urandom % 2), 1'($urandom % 2), 0, $sformatf("rand%0d", k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
